// File: rtl/pipelined_addsub_rca_pkg.sv
// ---------------------------------------------------------------------------
// rca_pkg
//   Shared definitions for the pipelined ripple-carry adder/subtractor.
//   OP_ADD / OP_SUB : encoding of the 'sub' operation select.
//   slice_w()       : width of one pipeline slice (WIDTH / STAGES).
//   params_ok()     : legal parameter combination (1 <= STAGES <= WIDTH and
//                     WIDTH divisible by STAGES).
// ---------------------------------------------------------------------------
package rca_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Guarded against a zero stage count so a bad parameter set still
    // reaches the elaboration check instead of dividing by zero.
    function automatic int slice_w(input int width, input int stages);
        int res;
        res = width;
        if (stages >= 1) begin
            res = width / stages;
        end else begin
            res = width;
        end
        return res;
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        bit ok;
        ok = 1'b0;
        if ((stages >= 1) && (stages <= width)) begin
            ok = ((width % stages) == 0);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/pipelined_addsub_rca_if.sv
// ---------------------------------------------------------------------------
// pipelined_addsub_rca_if
//   Streaming bus of the pipelined adder/subtractor.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, sum, cout, ovf
//   master : the producer/consumer around the block (testbench, parent)
//   slave  : the adder/subtractor itself
// ---------------------------------------------------------------------------
interface pipelined_addsub_rca_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_addsub_rca_slice.sv
// ---------------------------------------------------------------------------
// rca_full_adder : 1-bit full adder cell (a, b, ci -> s, co).
// rca_slice      : combinational W-bit ripple chain of rca_full_adder cells.
//   a, b      : slice operands
//   cin       : carry into bit 0
//   sum       : slice sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (used for signed overflow)
// ---------------------------------------------------------------------------
module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    // Sum and majority carry of the three inputs.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end
endmodule

module rca_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);
    logic [W:0] c_s;

    // Chain endpoints: slice carry-in and the two top carries.
    always_comb begin
        c_s[0]   = cin;
        cout     = c_s[W];
        c_msb_in = c_s[W-1];
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        rca_full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c_s[i]),
            .s  (sum[i]),
            .co (c_s[i+1])
        );
    end
endmodule

// File: rtl/pipelined_addsub_rca.sv
// ---------------------------------------------------------------------------
// pipelined_addsub_rca
//   Pipelined ripple-carry adder/subtractor. The operands are cut into
//   STAGES slices of WIDTH/STAGES bits; slice k is added in pipeline stage k
//   using the carry registered by stage k-1, so the critical path is one
//   slice long. Latency is STAGES cycles; one result per cycle when the
//   consumer is ready. A single global advance enable stalls every stage.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of pipelined_addsub_rca_if
//          sub=0 -> sum = a + b + cin ; sub=1 -> sum = a - b (cin ignored)
//          cout = carry out of MSB (sub: 1 means no borrow)
//          ovf  = carry into MSB xor carry out of MSB
// ---------------------------------------------------------------------------
module pipelined_addsub_rca
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_addsub_rca_if.slave bus
);
    localparam int SW = slice_w(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_addsub_rca: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             adv_s;
    logic             last_valid_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;

    // Subtraction is a + ~b + 1, so the operand is inverted and the carry forced.
    always_comb begin
        b_eff_s   = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
        cin_eff_s = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;
    end

    // Handshake: the whole pipeline advances unless a held result is refused.
    always_comb begin
        adv_s        = !last_valid_s || bus.out_ready;
        bus.in_ready = adv_s;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added shrink by one slice per stage,
        // while the finished low result grows by one slice per stage.
        localparam int IN_W  = WIDTH - k * SW;
        localparam int RES_W = (k + 1) * SW;

        logic [IN_W-1:0]  op_a_s;
        logic [IN_W-1:0]  op_b_s;
        logic             c_in_s;
        logic             v_in_s;
        logic [SW-1:0]    slice_sum_s;
        logic             slice_cout_s;
        logic             slice_cmsb_s;
        logic [RES_W-1:0] res_next_s;

        logic             valid_r;
        logic             carry_r;
        logic [RES_W-1:0] res_r;

        if (k == 0) begin : g_src
            // Stage 0 takes operands straight from the bus.
            always_comb begin
                op_a_s     = bus.a;
                op_b_s     = b_eff_s;
                c_in_s     = cin_eff_s;
                v_in_s     = bus.in_valid;
                res_next_s = slice_sum_s;
            end
        end else begin : g_src
            // Later stages take the forwarded upper operands and previous carry.
            always_comb begin
                op_a_s     = g_stage[k-1].g_fwd.a_r;
                op_b_s     = g_stage[k-1].g_fwd.b_r;
                c_in_s     = g_stage[k-1].carry_r;
                v_in_s     = g_stage[k-1].valid_r;
                res_next_s = {slice_sum_s, g_stage[k-1].res_r};
            end
        end

        rca_slice #(.W(SW)) u_slice (
            .a        (op_a_s[SW-1:0]),
            .b        (op_b_s[SW-1:0]),
            .cin      (c_in_s),
            .sum      (slice_sum_s),
            .cout     (slice_cout_s),
            .c_msb_in (slice_cmsb_s)
        );

        // Stage valid, carry and accumulated low result; hold on stall.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_r <= 1'b0;
                carry_r <= 1'b0;
                res_r   <= '0;
            end else if (adv_s) begin
                valid_r <= v_in_s;
                carry_r <= slice_cout_s;
                res_r   <= res_next_s;
            end else begin
                valid_r <= valid_r;
                carry_r <= carry_r;
                res_r   <= res_r;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IN_W-SW-1:0] a_r;
            logic [IN_W-SW-1:0] b_r;

            // Skew registers for operand slices not yet consumed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv_s) begin
                    a_r <= op_a_s[IN_W-1:SW];
                    b_r <= op_b_s[IN_W-1:SW];
                end else begin
                    a_r <= a_r;
                    b_r <= b_r;
                end
            end
        end else begin : g_last
            logic ovf_r;

            // Signed overflow from the two carries around the MSB.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (adv_s) begin
                    ovf_r <= slice_cmsb_s ^ slice_cout_s;
                end else begin
                    ovf_r <= ovf_r;
                end
            end
        end
    end

    // Result bus is driven directly from the last stage's registers.
    always_comb begin
        last_valid_s  = g_stage[STAGES-1].valid_r;
        bus.out_valid = g_stage[STAGES-1].valid_r;
        bus.sum       = g_stage[STAGES-1].res_r;
        bus.cout      = g_stage[STAGES-1].carry_r;
        bus.ovf       = g_stage[STAGES-1].g_last.ovf_r;
    end
endmodule

// File: tb/tb_pipelined_addsub_rca.sv
// ---------------------------------------------------------------------------
// tb_pipelined_addsub_rca
//   Drives three instances (STAGES = 4, 1, 16; WIDTH = 16) with the same
//   stimulus. A scoreboard per instance pushes the expected result on each
//   input transfer and pops/compares on each output transfer. A vector table
//   checks fixed results and exact latency; hand sequences cover
//   backpressure and reset with operations in flight.
// ---------------------------------------------------------------------------
module tb_pipelined_addsub_rca;
    import rca_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    localparam int STG [3] = '{4, 1, 16};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        cin;
    logic        sub;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;

    always #5 clk = ~clk;

    pipelined_addsub_rca_if #(.WIDTH(16)) if4 ();
    pipelined_addsub_rca_if #(.WIDTH(16)) if1 ();
    pipelined_addsub_rca_if #(.WIDTH(16)) if16 ();

    assign if4.in_valid  = in_valid;  assign if4.a  = a; assign if4.b  = b;
    assign if4.cin       = cin;       assign if4.sub  = sub; assign if4.out_ready = out_ready;
    assign if1.in_valid  = in_valid;  assign if1.a  = a; assign if1.b  = b;
    assign if1.cin       = cin;       assign if1.sub  = sub; assign if1.out_ready = out_ready;
    assign if16.in_valid = in_valid;  assign if16.a = a; assign if16.b = b;
    assign if16.cin      = cin;       assign if16.sub = sub; assign if16.out_ready = out_ready;

    pipelined_addsub_rca #(.WIDTH(16), .STAGES(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
    pipelined_addsub_rca #(.WIDTH(16), .STAGES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1.slave));
    pipelined_addsub_rca #(.WIDTH(16), .STAGES(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    logic        ov [3];
    logic        ir [3];
    logic        co [3];
    logic        of [3];
    logic [15:0] sm [3];

    assign ov[0] = if4.out_valid;  assign ir[0] = if4.in_ready;  assign co[0] = if4.cout;
    assign of[0] = if4.ovf;        assign sm[0] = if4.sum;
    assign ov[1] = if1.out_valid;  assign ir[1] = if1.in_ready;  assign co[1] = if1.cout;
    assign of[1] = if1.ovf;        assign sm[1] = if1.sum;
    assign ov[2] = if16.out_valid; assign ir[2] = if16.in_ready; assign co[2] = if16.cout;
    assign of[2] = if16.ovf;       assign sm[2] = if16.sum;

    exp_t sbq [3][$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pop_cnt [3];

    function automatic exp_t model(input logic [15:0] fa, input logic [15:0] fb,
                                   input logic fcin, input logic fsub);
        logic [15:0] beff;
        logic [16:0] t;
        exp_t        r;
        beff  = fsub ? ~fb : fb;
        t     = {1'b0, fa} + {1'b0, beff} + {16'd0, (fsub ? 1'b1 : fcin)};
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (fa[15] == beff[15]) && (t[15] != fa[15]);
        return r;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (stages=%0d): got %0h, expected %0h", name, STG[d], act, exp);
        end
    endtask

    // Scoreboard monitor, sampling 2 time units after each falling edge.
    initial begin : monitor
        logic hold_p [3];
        exp_t held [3];
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    sbq[d].delete();
                    hold_p[d] = 1'b0;
                end else begin
                    if (hold_p[d]) begin
                        check("hold_valid", d, ov[d], 1);
                        check("hold_sum", d, sm[d], held[d].sum);
                        check("hold_cout", d, co[d], held[d].cout);
                        check("hold_ovf", d, of[d], held[d].ovf);
                    end
                    check("in_ready", d, ir[d], (!ov[d] || out_ready));
                    if (ov[d] && out_ready) begin
                        if (sbq[d].size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_out (stages=%0d): got sum %0h, expected no output", STG[d], sm[d]);
                        end else begin
                            e = sbq[d].pop_front();
                            check("sb_sum", d, sm[d], e.sum);
                            check("sb_cout", d, co[d], e.cout);
                            check("sb_ovf", d, of[d], e.ovf);
                            pop_cnt[d]++;
                        end
                    end
                    if (in_valid && ir[d]) begin
                        sbq[d].push_back(model(a, b, cin, sub));
                    end
                    hold_p[d] = ov[d] && !out_ready;
                    held[d]   = '{sm[d], co[d], of[d]};
                end
            end
        end
    end

    // One operation into an idle pipeline; checks table result and latency.
    task automatic lat_test(input vec_t v);
        int lat [3];
        lat = '{0, 0, 0};
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #2;
            for (int d = 0; d < 3; d++) begin
                if (lat[d] == 0 && ov[d]) begin
                    lat[d] = c;
                    check("tbl_sum", d, sm[d], v.sum);
                    check("tbl_cout", d, co[d], v.cout);
                    check("tbl_ovf", d, of[d], v.ovf);
                end
            end
        end
        for (int d = 0; d < 3; d++) check("latency", d, lat[d], STG[d]);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t        tbl [6];
        logic [15:0] sa [10];
        logic [15:0] sb [10];
        logic        sc [10];
        logic        ss [10];
        int          i;
        int          cyc;
        int          stall_cnt;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};

        pop_cnt = '{0, 0, 0};

        // Reset with random inputs applied.
        rst = 1'b1;
        in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom); out_ready = 1'($urandom);
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_out_valid", d, ov[d], 0);
            check("rst_sum", d, sm[d], 0);
            check("rst_cout", d, co[d], 0);
            check("rst_ovf", d, of[d], 0);
            check("rst_in_ready", d, ir[d], 1);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        // Fixed vectors: add, wrap, overflow, subtract, on all three depths.
        for (int k = 0; k < 5; k++) lat_test(tbl[k]);

        // Ten back-to-back ops with out_ready low for six cycles.
        for (int k = 0; k < 10; k++) begin
            sa[k] = 16'($urandom); sb[k] = 16'($urandom);
            sc[k] = 1'($urandom);  ss[k] = 1'($urandom);
        end
        pop_cnt = '{0, 0, 0};
        i = 0; cyc = 0; stall_cnt = 0;
        while (i < 10 && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 10);
            a = sa[i]; b = sb[i]; cin = sc[i]; sub = ss[i]; in_valid = 1'b1;
            #2;
            if (!ir[0]) stall_cnt++;
            if (ir[0]) i++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_accepted", 0, i, 10);
        check("stall_cycles", 0, stall_cnt, 6);
        repeat (40) @(negedge clk);
        #3;
        check("stream_results", 0, pop_cnt[0], 10);
        for (int d = 0; d < 3; d++) check("drain_empty", d, sbq[d].size(), 0);

        // Reset with three ops in flight, then a single new op.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat_test(tbl[5]);
        #3;
        for (int d = 0; d < 3; d++) check("final_empty", d, sbq[d].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
